// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
//
// Parameters: WIDTH (operand bits), GROUP (bits per lookahead group),
//             GROUPS_PER_STAGE (groups resolved per pipeline stage).
//             STAGES = WIDTH / (GROUP*GROUPS_PER_STAGE).
// Ports:
//   clock, reset_n             clock and synchronous active-low reset
//   in_valid, in_ready         operand handshake
//   data_operandA/B, sub       operands; sub=1 computes A-B
//   out_valid, out_ready       result handshake
//   Sum, Cout                  registered result and carry out (1 = no borrow on subtract)
//   Ovf, Zero                  signed overflow and zero flag, only with CLA_FLAGS_EN defined
// Optional feature macro: CLA_FLAGS_EN
//
// Pipeline layout: a capture register (index 0) holds conditioned operands,
// then STAGES registers (index 1..STAGES), each adding one slice. Index
// STAGES is the output register, so latency is STAGES cycles from capture.

module cla_pipe_addsub #(
    parameter int WIDTH            = 32,
    parameter int GROUP            = 4,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             Ovf,
    output logic             Zero
`endif
);

    localparam int SL     = GROUP * GROUPS_PER_STAGE;
    localparam int STAGES = WIDTH / SL;

    if ((WIDTH % SL) != 0) begin : g_width_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP*GROUPS_PER_STAGE");
    end

    logic             v_q [0:STAGES];
    logic [WIDTH-1:0] s_q [0:STAGES];
    logic             c_q [0:STAGES];
    logic [WIDTH-1:0] a_q [0:STAGES-1];
    logic [WIDTH-1:0] b_q [0:STAGES-1];

    logic [WIDTH-1:0] sum_n  [0:STAGES-1];
    logic             cout_n [0:STAGES-1];

`ifdef CLA_FLAGS_EN
    logic             z_q   [0:STAGES];
    logic             ovf_q;
    logic             zs_n  [0:STAGES-1];
    logic             msb_cin;
`endif

    logic advance;

    // Global stall: everything moves together or nothing moves.
    assign advance   = !v_q[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES];
    assign Sum       = s_q[STAGES];
    assign Cout      = c_q[STAGES];
`ifdef CLA_FLAGS_EN
    assign Ovf       = ovf_q;
    assign Zero      = z_q[STAGES];
`endif

    // Slice arithmetic for every stage. Group P/G are formed over the whole
    // group, group carries chain as C(i+1) = G(i) | P(i)&C(i); the bit-level
    // carries inside a group only produce the sum bits.
    always_comb begin
        logic c;
        logic cb;
        logic gg;
        logic gp;
        logic p;
        logic g;
        int   bi;
        c  = 1'b0;
        cb = 1'b0;
        gg = 1'b0;
        gp = 1'b0;
        p  = 1'b0;
        g  = 1'b0;
        bi = 0;
`ifdef CLA_FLAGS_EN
        msb_cin = 1'b0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            sum_n[k] = s_q[k];
            c        = c_q[k];
            for (int gi = 0; gi < GROUPS_PER_STAGE; gi++) begin
                gg = 1'b0;
                gp = 1'b1;
                cb = c;
                for (int j = 0; j < GROUP; j++) begin
                    bi = k * SL + gi * GROUP + j;
                    p  = a_q[k][bi] ^ b_q[k][bi];
                    g  = a_q[k][bi] & b_q[k][bi];
                    gg = g | (p & gg);
                    gp = gp & p;
                    sum_n[k][bi] = p ^ cb;
`ifdef CLA_FLAGS_EN
                    if (bi == WIDTH - 1) begin
                        msb_cin = cb;
                    end
`endif
                    cb = g | (p & cb);
                end
                c = gg | (gp & c);
            end
            cout_n[k] = c;
`ifdef CLA_FLAGS_EN
            zs_n[k] = (sum_n[k][k*SL +: SL] == '0);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k <= STAGES; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
`ifdef CLA_FLAGS_EN
                z_q[k] <= 1'b0;
`endif
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
`ifdef CLA_FLAGS_EN
            ovf_q <= 1'b0;
`endif
        end else if (advance) begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                a_q[0] <= data_operandA;
                b_q[0] <= data_operandB ^ {WIDTH{sub}};
                c_q[0] <= sub;
                s_q[0] <= '0;
`ifdef CLA_FLAGS_EN
                z_q[0] <= 1'b1;
`endif
            end
            for (int k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                // Data fields only load behind a valid entry, so the output
                // register keeps the last result when a bubble arrives.
                if (v_q[k]) begin
                    s_q[k+1] <= sum_n[k];
                    c_q[k+1] <= cout_n[k];
`ifdef CLA_FLAGS_EN
                    z_q[k+1] <= z_q[k] & zs_n[k];
`endif
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (v_q[k]) begin
                    a_q[k+1] <= a_q[k];
                    b_q[k+1] <= b_q[k];
                end
            end
`ifdef CLA_FLAGS_EN
            if (v_q[STAGES-1]) begin
                ovf_q <= msb_cin ^ cout_n[STAGES-1];
            end
`endif
        end
    end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. It generalises the CPU's fixed 32-bit combinational CLA. Operand width, lookahead group size and pipeline depth are all configurable, and in-flight results stall under downstream backpressure. The block sits between operand issue and writeback in the ALU path and in the decryption datapath's modular-add stages, where widths above 32 bits must close timing.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits.
- `GROUP`, default 4: bits per carry-lookahead group; group P/G is computed in parallel within a group.
- `GROUPS_PER_STAGE`, default 2: lookahead groups resolved per pipeline stage.
  - `STAGES` = `WIDTH`/(`GROUP`*`GROUPS_PER_STAGE`), derived. Default is 4.
  - `WIDTH` not divisible by `GROUP`*`GROUPS_PER_STAGE` is an elaboration error.

Ports:
- `clock`  in  1  single clock, rising edge. One clock; all state is in this domain.
- `reset_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operands presented.
- `in_ready`  out  1  block can accept this cycle.
- `data_operandA`  in  `WIDTH`  operand A.
- `data_operandB`  in  `WIDTH`  operand B.
- `sub`  in  1  1 = A−B (B inverted, carry-in 1); 0 = A+B.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts result.
- `Sum`  out  `WIDTH`  result, modulo 2^`WIDTH`.
- `Cout`  out  1  carry out of the MSB. For subtraction, 1 = no borrow.
- `Ovf`  out  1  signed overflow. Present only with `CLA_FLAGS_EN`.
- `Zero`  out  1  `Sum` == 0. Present only with `CLA_FLAGS_EN`.

## Operation
- Transfer in: `in_valid` && `in_ready` on a rising edge. Transfer out: `out_valid` && `out_ready`.
- Operand conditioning at capture: B_in = `data_operandB` XOR {`WIDTH`{`sub`}}; carry-in c0 = `sub`.
- Stage k (0..`STAGES`−1):
  - Computes `Sum` bits for slice k, which covers `GROUP`*`GROUPS_PER_STAGE` bits starting at bit k*`GROUP`*`GROUPS_PER_STAGE`.
  - Uses the registered carry from stage k−1 (c0 for stage 0).
  - Within the slice, the group carries are a lookahead chain: C(i+1) = G(i) | P(i)&C(i).
  - Each stage register holds: valid bit, completed low sum slices, remaining high A/B_in slices, slice carry-out.
- The last stage drives `Sum` and `Cout` from its register; there is no combinational path from inputs to outputs.
- Stall rule: advance = !`out_valid` || `out_ready`. When advance = 0, every stage register holds its value, bubbles included. The stall is global; bubbles are not compressed.
- `in_ready` = advance. It is combinational from `out_ready` and registered `out_valid`. There is no path from `in_valid` to `in_ready`.
- A bubble (stage valid = 0) moves through like data. Its data fields are don't-care internally, but `Sum`/`Cout` are not updated when a bubble reaches the output register. The outputs hold the last result value.
- `out_valid` stays asserted and `Sum`/`Cout`/flags stay stable until the output transfer.

## Timing
- Latency: an operand accepted at edge n gives `out_valid`=1 after edge n+`STAGES`, provided there are no stalls. The default is 4 cycles.
- Throughput: one operation per cycle while `out_ready`=1.
- Each stall cycle adds exactly one cycle of latency to every in-flight operation.
- Reset (`reset_n`=0 at a rising edge):
  - All stage valid bits clear; `out_valid`=0, `Sum`=0, `Cout`=0, `Ovf`=0, `Zero`=0.
  - `in_ready`=1 in the first cycle after reset, because `out_valid`=0.
  - Reset mid-operation discards all in-flight results with no partial output.
  - Inputs are ignored while `reset_n`=0.
- Simultaneous output transfer and input transfer in the same cycle is legal; the pipeline shifts by one.
- Full pipeline with `out_ready`=0: `in_ready`=0 and no input is accepted. Nothing is overwritten.
- Empty pipeline: `out_valid`=0 and the outputs hold their last values.
- Wrap-around: the sum is modulo 2^`WIDTH`. The carry out of the top bit goes to `Cout` only.

## Configuration
- Macro: `CLA_FLAGS_EN`.
- Defined:
  - `Ovf` and `Zero` ports exist.
  - `Ovf` = (carry into bit `WIDTH`−1) XOR `Cout`, registered with the final stage.
  - `Zero` is computed as the AND of per-stage slice-zero bits, carried along the pipeline and registered with `Sum`.
  - Both flags follow the same valid/stall rules as `Sum`.
- Undefined: the ports, the slice-zero registers and the MSB carry-in register are absent. All other behaviour is identical.

## Test plan
- Reset then single add, default parameters:
  - Stimulus: A=0xFFFF_FFFF, B=0x0000_0001, `sub`=0.
  - Response: exactly 4 cycles later `out_valid`=1, `Sum`=0, `Cout`=1; with flags, `Zero`=1, `Ovf`=0.
- Subtract with signed overflow:
  - Stimulus: A=0x8000_0000, B=0x0000_0001, `sub`=1.
  - Response: `Sum`=0x7FFF_FFFF, `Cout`=1, `Ovf`=1.
- Back-to-back stream of 16 random operand pairs with `out_ready`=1: 16 results in order on consecutive cycles; each matches the reference model for A±B.
- Backpressure:
  - Stimulus: fill the pipeline, hold `out_ready`=0 for 5 cycles, then release.
  - Response: `in_ready`=0 throughout the hold; `Sum` stable; no result lost or duplicated; order preserved.
- Reset mid-stream: assert `reset_n`=0 for 1 cycle with 3 operations in flight. No `out_valid` follows for those operations; the next accepted operation appears after `STAGES` cycles.
- Parameter sweep, `WIDTH`=64, `GROUP`=8, `GROUPS_PER_STAGE`=1:
  - Stimulus: A=2^63, B=2^63, `sub`=0.
  - Response: latency 8 cycles, `Sum`=0, `Cout`=1.
